multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
// - Successor of the single-cycle control decoder. Sequences a multicycle RV32I datapath through
//   FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, one strobe per architectural update.
// - Holds the instruction in an internal IR, handshakes with instruction/data memory, times out stalled
//   accesses, traps illegal encodings. Sits between the memories and the datapath muxes/ALU/register file.
// PARAMETERS
// - TIMEOUT       16  cycles without ack before bus-error trap (>=1); counter width $clog2(TIMEOUT+1)
// - ILLEGAL_HALT   1  1: TRAP held until rst; 0: one TRAP cycle, PCWr (skip instr), back to FETCH
// PORTS
// - clk          in   1  sole clock, rising edge
// - rst          in   1  synchronous, active-high reset
// - Instr        in  32  instruction memory read data, sampled on IMAck
// - IMAck, DMAck in   1  memory acks; ignored outside FETCH / MEMORY respectively
// - BrTaken      in   1  branch unit result, valid in EXECUTE
// - MDDone       in   1  mul/div unit done (MULDIV_EN only)
// - IMReq        out  1  instruction fetch request
// - IRWr, PCWr   out  1  IR load strobe; PC update strobe
// - RUWr         out  1  register file write strobe
// - ALUOp        out  4  {F7[5],F3} OP / OP-IMM shifts; {0,F3} other OP-IMM; 0111 LUI; 0000 else
// - ImmSrc       out  3  I=000 S=001 B=101 U=010 J=110
// - ALUASrc      out  1  1=PC (AUIPC, JAL, BRANCH), 0=rs1
// - ALUBSrc      out  1  0 for OP only (rs2), else imm
// - DMRd, DMWr   out  1  data memory read / write request
// - DMCtrl       out  3  F3 (size/sign)
// - BrOp         out  5  {~op[4]&op[2], op[6], F3}
// - RUDataWrSrc  out  2  00 ALU, 01 DM, 10 PC+4, 11 mul/div
// - MDStart, MDOp out 1,3  mul/div start pulse, F3
// - Trap, TrapCause out 1,2  01 illegal, 10 IM timeout, 11 DM timeout
// - State        out  3  current state (debug)
// BEHAVIOUR
// - rst high at posedge: state<=FETCH, IR<=32'h00000013, counter<=0, TrapCause<=00; while rst high all
//   strobes/requests (IMReq IRWr PCWr RUWr DMRd DMWr MDStart Trap) forced 0. rst beats every other input.
// - Moore outputs from state+IR; datapath controls combinational from IR, stable DECODE..end of instr.
// - FETCH: IMReq=1; IMAck -> IRWr=1 same cycle, ->DECODE. Counter +1 per unacked cycle, cleared on each
//   state entry; reaching TIMEOUT -> TRAP cause 10.
// - DECODE (1 cycle): opcode outside {LUI AUIPC JAL JALR BRANCH LOAD STORE OP-IMM OP} or bad F7/F3
//   -> TRAP cause 01; else ->EXECUTE.
// - EXECUTE (1 cycle): LOAD/STORE ->MEMORY; BRANCH ->FETCH with PCWr=1 (datapath picks target/PC+4 via
//   BrTaken); others ->WRITEBACK.
// - MEMORY: DMRd/DMWr held until DMAck; store+ack ->FETCH with PCWr=1; load+ack ->WRITEBACK;
//   timeout -> TRAP cause 11, DMWr drops that cycle.
// - WRITEBACK (1 cycle): RUWr=1, PCWr=1 exactly once, ->FETCH. x0 filtered by register file.
// - TRAP: Trap=1; per ILLEGAL_HALT. TrapCause holds until next trap or rst.
// - Instruction latency: ALU 4 cycles + fetch wait; load 5 + waits; branch/store 3-4 + waits.
// CONFIGURATION
// - MULDIV_EN defined: OP with F7=0000001 legal; EXECUTE pulses MDStart 1 cycle, enters MULDIV state
//   until MDDone (no timeout), then WRITEBACK with RUDataWrSrc=11.
// - MULDIV_EN undefined: F7=0000001 -> TRAP cause 01; MDStart/MDOp tied 0, MDDone ignored; ports kept.
// STRUCTURE
// - cu_pkg: opcode localparams, state_t enum (FETCH DECODE EXECUTE MEMORY WRITEBACK MULDIV TRAP),
//   trap cause, ImmSrc and RUDataWrSrc codes.
// - Sub-module cu_field_decoder: combinational IR -> datapath controls + Illegal flag; FSM, counter
//   and IR stay in top.
// TESTING
// - ADDI 32'h00500093, IMAck 2 cycles late -> one IRWr, ALUOp 0000, ALUBSrc 1, RUWr+PCWr once in WB.
// - LW 32'h0000A103, DMAck after 3 cycles -> DMRd high 4 cycles, DMCtrl 010, RUDataWrSrc 01, 1 RUWr.
// - BEQ, BrTaken=1 -> BrOp 01000, ImmSrc 101, PCWr in EXECUTE, RUWr never.
// - 32'hFFFFFFFF -> TrapCause 01; HALT=1 stays TRAP; HALT=0 PCWr then FETCH. MUL 32'h022081B3: with
//   MULDIV_EN MDStart pulse, wait MDDone, RUDataWrSrc 11; without -> TrapCause 01.
// - IMAck never, TIMEOUT=16 -> TRAP cause 10 after exactly 16 FETCH cycles.
// - rst mid-MEMORY on store (DMWr=1) -> DMWr 0 that cycle, State FETCH after release, no PCWr.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared opcodes, FSM states, trap causes and the decoded-control payload for the multicycle control unit.
package cu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_B = 3'b101;
    localparam logic [2:0] IMM_J = 3'b110;

    localparam logic [1:0] RU_ALU = 2'b00;
    localparam logic [1:0] RU_DM  = 2'b01;
    localparam logic [1:0] RU_PC4 = 2'b10;
    localparam logic [1:0] RU_MD  = 2'b11;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        MULDIV    = 3'd5,
        TRAP      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IM_TO   = 2'b10,
        CAUSE_DM_TO   = 2'b11
    } trap_cause_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] imm_src;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [2:0] dm_ctrl;
        logic [4:0] br_op;
        logic [1:0] ru_src;
        logic [2:0] md_op;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_muldiv;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/cu_field_decoder.sv
// Combinational IR field decoder: datapath controls plus legality. MULDIV_EN makes OP with F7=0000001 legal.
import cu_pkg::*;

module cu_field_decoder (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    logic op_legal;

    always_comb begin
        ctrl           = '0;
        op_legal       = 1'b0;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_b_src = 1'b1;
        ctrl.dm_ctrl   = funct3;
        ctrl.br_op     = {~opcode[4] & opcode[2], opcode[6], funct3};
        case (opcode)
            OP_LUI: begin
                ctrl.imm_src = IMM_U;
                ctrl.alu_op  = 4'b0111;
            end
            OP_AUIPC: begin
                ctrl.imm_src   = IMM_U;
                ctrl.alu_a_src = 1'b1;
            end
            OP_JAL: begin
                ctrl.imm_src   = IMM_J;
                ctrl.alu_a_src = 1'b1;
                ctrl.ru_src    = RU_PC4;
            end
            OP_JALR: begin
                ctrl.ru_src  = RU_PC4;
                ctrl.illegal = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                ctrl.imm_src   = IMM_B;
                ctrl.alu_a_src = 1'b1;
                ctrl.is_branch = 1'b1;
                ctrl.illegal   = (funct3 inside {3'b010, 3'b011});
            end
            OP_LOAD: begin
                ctrl.is_load = 1'b1;
                ctrl.ru_src  = RU_DM;
                ctrl.illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OP_STORE: begin
                ctrl.imm_src  = IMM_S;
                ctrl.is_store = 1'b1;
                ctrl.illegal  = (funct3 > 3'b010);
            end
            OP_IMM: begin
                // Shift-immediates carry the arithmetic/logical select in F7[5].
                if (funct3[1:0] == 2'b01) begin
                    ctrl.alu_op  = {funct7[5], funct3};
                    ctrl.illegal = (funct3 == 3'b001) ? (funct7 != 7'b0000000)
                                 : !(funct7 inside {7'b0000000, 7'b0100000});
                end else begin
                    ctrl.alu_op = {1'b0, funct3};
                end
            end
            OP_OP: begin
                ctrl.alu_b_src = 1'b0;
                ctrl.alu_op    = {funct7[5], funct3};
                op_legal       = (funct7 == 7'b0000000) ||
                                 ((funct7 == 7'b0100000) && (funct3 inside {3'b000, 3'b101}));
`ifdef MULDIV_EN
                ctrl.is_muldiv = (funct7 == 7'b0000001);
                if (ctrl.is_muldiv) begin
                    ctrl.ru_src = RU_MD;
                    ctrl.md_op  = funct3;
                end
                ctrl.illegal = !(op_legal || ctrl.is_muldiv);
`else
                ctrl.illegal = !op_legal;
`endif
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with IR, access timeout and trap handling. Optional mul/div via MULDIV_EN.
import cu_pkg::*;

module multicycle_control_unit #(
    parameter int unsigned TIMEOUT      = 16,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instr,
    input  logic        IMAck,
    input  logic        DMAck,
    input  logic        BrTaken,
    input  logic        MDDone,
    output logic        IMReq,
    output logic        IRWr,
    output logic        PCWr,
    output logic        RUWr,
    output logic [3:0]  ALUOp,
    output logic [2:0]  ImmSrc,
    output logic        ALUASrc,
    output logic        ALUBSrc,
    output logic        DMRd,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    output logic [4:0]  BrOp,
    output logic [1:0]  RUDataWrSrc,
    output logic        MDStart,
    output logic [2:0]  MDOp,
    output logic        Trap,
    output logic [1:0]  TrapCause,
    output logic [2:0]  State
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_next;
    trap_cause_t       cause, cause_next;
    logic [31:0]       ir;
    logic [CNT_W-1:0]  cnt;
    logic              timeout;
    ctrl_t             ctrl;
    logic              unused_bits;

    cu_field_decoder u_dec (
        .opcode (ir[6:0]),
        .funct3 (ir[14:12]),
        .funct7 (ir[31:25]),
        .ctrl   (ctrl)
    );

    // The branch target choice is made in the datapath; operand fields feed the register file directly.
`ifdef MULDIV_EN
    assign unused_bits = ^{BrTaken, ir[24:15], ir[11:7]};
`else
    assign unused_bits = ^{BrTaken, MDDone, ir[24:15], ir[11:7]};
`endif

    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cause <= CAUSE_NONE;
            ir    <= NOP_INSTR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (IRWr) begin
                ir <= Instr;
            end
            // Wait counter restarts on every state entry.
            if (state_next != state) begin
                cnt <= '0;
            end else if (state == FETCH || state == MEMORY) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_next = cause;
        IMReq      = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        RUWr       = 1'b0;
        DMRd       = 1'b0;
        DMWr       = 1'b0;
        MDStart    = 1'b0;
        case (state)
            FETCH: begin
                IMReq = 1'b1;
                if (IMAck) begin
                    IRWr       = 1'b1;
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_IM_TO;
                end
            end
            DECODE: begin
                if (ctrl.illegal) begin
                    state_next = TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                if (ctrl.is_load || ctrl.is_store) begin
                    state_next = MEMORY;
                end else if (ctrl.is_branch) begin
                    PCWr       = 1'b1;
                    state_next = FETCH;
                end else if (ctrl.is_muldiv) begin
                    MDStart    = 1'b1;
                    state_next = MULDIV;
                end else begin
                    state_next = WRITEBACK;
                end
            end
            MEMORY: begin
                DMRd = ctrl.is_load;
                DMWr = ctrl.is_store;
                if (DMAck) begin
                    if (ctrl.is_store) begin
                        PCWr       = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WRITEBACK;
                    end
                end else if (timeout) begin
                    DMWr       = 1'b0;
                    state_next = TRAP;
                    cause_next = CAUSE_DM_TO;
                end
            end
            WRITEBACK: begin
                RUWr       = 1'b1;
                PCWr       = 1'b1;
                state_next = FETCH;
            end
            MULDIV: begin
`ifdef MULDIV_EN
                if (MDDone) begin
                    state_next = WRITEBACK;
                end
`else
                state_next = FETCH;
`endif
            end
            TRAP: begin
                // Non-halting mode skips the offending instruction.
                if (!ILLEGAL_HALT) begin
                    PCWr       = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        if (rst) begin
            IMReq   = 1'b0;
            IRWr    = 1'b0;
            PCWr    = 1'b0;
            RUWr    = 1'b0;
            DMRd    = 1'b0;
            DMWr    = 1'b0;
            MDStart = 1'b0;
        end
    end

    assign Trap        = (state == TRAP) && !rst;
    assign TrapCause   = cause;
    assign State       = state;
    assign ALUOp       = ctrl.alu_op;
    assign ImmSrc      = ctrl.imm_src;
    assign ALUASrc     = ctrl.alu_a_src;
    assign ALUBSrc     = ctrl.alu_b_src;
    assign DMCtrl      = ctrl.dm_ctrl;
    assign BrOp        = ctrl.br_op;
    assign RUDataWrSrc = ctrl.ru_src;
    assign MDOp        = ctrl.md_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction cycle-trace model plus literal spot checks.
import cu_pkg::*;

module tb_multicycle_control_unit;

    localparam int unsigned TO   = 16;
    localparam bit          HALT = 1'b1;

    localparam logic [7:0] S_IMREQ = 8'h80, S_IRWR = 8'h40, S_PCWR = 8'h20, S_RUWR = 8'h10;
    localparam logic [7:0] S_DMRD  = 8'h08, S_DMWR = 8'h04, S_MDST = 8'h02, S_TRAP = 8'h01;

    localparam logic [31:0] I_ADDI  = 32'h00500093, I_LW   = 32'h0000A103, I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SW    = 32'h0020A223, I_SUB  = 32'h40208033, I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_JAL   = 32'h008000EF, I_SRAI = 32'h4010D093, I_AUIPC = 32'h00001117;
    localparam logic [31:0] I_MUL   = 32'h022081B3, I_BADLD = 32'h0000B103, I_ONES = 32'hFFFFFFFF;

    typedef struct packed {
        logic        rst, imack, dmack, mddone, brtaken;
        logic [31:0] instr;
    } stim_t;

    typedef struct packed {
        logic        chk_st, chk_dp;
        logic [2:0]  st;
        logic [7:0]  strb;
        logic [1:0]  cause;
        logic [21:0] dp;
    } exp_t;

    typedef struct packed {
        logic        ill, ld, st, br, md;
        logic [21:0] dp;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, IMAck, DMAck, BrTaken, MDDone;
    logic [31:0] Instr;
    logic IMReq, IRWr, PCWr, RUWr, ALUASrc, ALUBSrc, DMRd, DMWr, MDStart, Trap;
    logic [3:0] ALUOp;
    logic [2:0] ImmSrc, DMCtrl, MDOp, State;
    logic [4:0] BrOp;
    logic [1:0] RUDataWrSrc, TrapCause;

    logic rst2, ack2;
    logic [31:0] instr2;
    logic n_imreq, n_irwr, n_pcwr, n_ruwr, n_asrc, n_bsrc, n_dmrd, n_dmwr, n_mdst, n_trap;
    logic [3:0] n_aluop;
    logic [2:0] n_imm, n_dmc, n_mdop, n_state;
    logic [4:0] n_brop;
    logic [1:0] n_rus, n_cause;

    multicycle_control_unit #(.TIMEOUT(TO), .ILLEGAL_HALT(HALT)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .IMAck(IMAck), .DMAck(DMAck), .BrTaken(BrTaken),
        .MDDone(MDDone), .IMReq(IMReq), .IRWr(IRWr), .PCWr(PCWr), .RUWr(RUWr), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .DMRd(DMRd), .DMWr(DMWr),
        .DMCtrl(DMCtrl), .BrOp(BrOp), .RUDataWrSrc(RUDataWrSrc), .MDStart(MDStart), .MDOp(MDOp),
        .Trap(Trap), .TrapCause(TrapCause), .State(State)
    );

    multicycle_control_unit #(.TIMEOUT(TO), .ILLEGAL_HALT(1'b0)) dut_nh (
        .clk(clk), .rst(rst2), .Instr(instr2), .IMAck(ack2), .DMAck(1'b0), .BrTaken(1'b0),
        .MDDone(1'b0), .IMReq(n_imreq), .IRWr(n_irwr), .PCWr(n_pcwr), .RUWr(n_ruwr), .ALUOp(n_aluop),
        .ImmSrc(n_imm), .ALUASrc(n_asrc), .ALUBSrc(n_bsrc), .DMRd(n_dmrd), .DMWr(n_dmwr),
        .DMCtrl(n_dmc), .BrOp(n_brop), .RUDataWrSrc(n_rus), .MDStart(n_mdst), .MDOp(n_mdop),
        .Trap(n_trap), .TrapCause(n_cause), .State(n_state)
    );

    int n_checks = 0, errors = 0;
    int c_irwr, c_ruwr, c_pcwr, c_dmrd, c_fetch, c_mdst;
    logic [21:0] cap_dp;
    logic [1:0]  mcause;
    stim_t sq[$];
    exp_t  eq[$];

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Decoding rules of the control table, in terms of instruction classes.
    function automatic mdl_t model(input logic [31:0] ins);
        logic [6:0] op, f7;
        logic [2:0] f3, imm, mdop;
        logic [3:0] aluop;
        logic [1:0] rus;
        logic       asrc, bsrc;
        mdl_t m;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        m = '0; aluop = 4'd0; imm = 3'b000; asrc = 1'b0; bsrc = 1'b1; rus = 2'd0; mdop = 3'd0;
        case (op)
            7'h37: begin aluop = 4'b0111; imm = 3'b010; end
            7'h17: begin imm = 3'b010; asrc = 1'b1; end
            7'h6F: begin imm = 3'b110; asrc = 1'b1; rus = 2'd2; end
            7'h67: begin rus = 2'd2; m.ill = (f3 != 3'd0); end
            7'h63: begin imm = 3'b101; asrc = 1'b1; m.br = 1'b1; m.ill = (f3 == 3'd2 || f3 == 3'd3); end
            7'h03: begin m.ld = 1'b1; rus = 2'd1; m.ill = (f3 == 3'd3 || f3 > 3'd5); end
            7'h23: begin imm = 3'b001; m.st = 1'b1; m.ill = (f3 > 3'd2); end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    aluop = {f7[5], f3};
                    m.ill = (f3 == 3'd1) ? (f7 != 7'h00) : (f7 != 7'h00 && f7 != 7'h20);
                end else aluop = {1'b0, f3};
            end
            7'h33: begin
                bsrc = 1'b0; aluop = {f7[5], f3};
                if (f7 == 7'h01) begin
`ifdef MULDIV_EN
                    m.md = 1'b1; rus = 2'd3; mdop = f3;
`else
                    m.ill = 1'b1;
`endif
                end else m.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            default: m.ill = 1'b1;
        endcase
        m.dp = {aluop, imm, asrc, bsrc, f3, {~op[4] & op[2], op[6], f3}, rus, mdop};
        return m;
    endfunction

    function automatic stim_t sv(input logic [31:0] ins, input logic im, input logic dm,
                                 input logic md, input logic br);
        stim_t s;
        s.rst = 1'b0; s.imack = im; s.dmack = dm; s.mddone = md; s.brtaken = br; s.instr = ins;
        return s;
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic [7:0] strb);
        exp_t e;
        e = '0; e.chk_st = 1'b1; e.st = st; e.strb = strb; e.cause = mcause;
        return e;
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        sq.push_back(s);
        eq.push_back(e);
    endtask

    task automatic push_trap(input logic [1:0] c, input logic [31:0] ins);
        mcause = c;
        if (HALT) repeat (2) push(sv(ins, 0, 0, 0, 0), mk(TRAP, S_TRAP));
        else push(sv(ins, 0, 0, 0, 0), mk(TRAP, S_TRAP | S_PCWR));
    endtask

    task automatic push_reset(input logic [2:0] prev, input logic chk_prev, input int n);
        stim_t s;
        exp_t  e;
        s = sv(NOP_INSTR, 0, 0, 0, 0); s.rst = 1'b1;
        e = mk(prev, 8'h00); e.chk_st = chk_prev;
        push(s, e);
        mcause = 2'b00;
        for (int k = 1; k < n; k++) push(s, mk(FETCH, 8'h00));
    endtask

    // Expected cycle trace of one instruction given memory wait counts.
    task automatic push_instr(input logic [31:0] ins, input int imw, input int dmw, input int mdw,
                              input logic br, input int rst_mem);
        mdl_t m;
        exp_t e;
        logic [7:0] rq;
        m = model(ins);
        for (int k = 0; k < imw; k++) begin
            push(sv(ins, 0, 0, 0, 0), mk(FETCH, S_IMREQ));
            if (k == TO - 1) begin push_trap(2'b10, ins); return; end
        end
        push(sv(ins, 1, 0, 0, 0), mk(FETCH, S_IMREQ | S_IRWR));
        e = mk(DECODE, 8'h00); e.chk_dp = 1'b1; e.dp = m.dp;
        push(sv(ins, 0, 0, 0, 0), e);
        if (m.ill) begin push_trap(2'b01, ins); return; end
        e.st = EXECUTE; e.strb = m.br ? S_PCWR : (m.md ? S_MDST : 8'h00);
        push(sv(ins, 0, 0, 0, br), e);
        if (m.br) return;
        if (m.md) begin
            e.st = MULDIV; e.strb = 8'h00;
            for (int k = 0; k < mdw; k++) push(sv(ins, 0, 0, 0, 0), e);
            push(sv(ins, 0, 0, 1, 0), e);
        end else if (m.ld || m.st) begin
            rq = m.ld ? S_DMRD : S_DMWR;
            e.st = MEMORY;
            for (int k = 0; k < dmw; k++) begin
                if (k == rst_mem) begin push_reset(MEMORY, 1'b1, 1); return; end
                e.strb = (k == TO - 1 && m.st) ? 8'h00 : rq;
                push(sv(ins, 0, 0, 0, 0), e);
                if (k == TO - 1) begin push_trap(2'b11, ins); return; end
            end
            e.strb = rq | (m.st ? S_PCWR : 8'h00);
            push(sv(ins, 0, 1, 0, 0), e);
            if (m.st) return;
        end
        e.st = WRITEBACK; e.strb = S_RUWR | S_PCWR;
        push(sv(ins, 0, 0, 0, 0), e);
    endtask

    // Drive each queued cycle and compare against its expectation.
    task automatic play();
        stim_t s;
        exp_t  e;
        logic [7:0]  a_strb;
        logic [21:0] a_dp;
        c_irwr = 0; c_ruwr = 0; c_pcwr = 0; c_dmrd = 0; c_fetch = 0; c_mdst = 0; cap_dp = '0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            e = eq.pop_front();
            @(posedge clk); #1;
            rst = s.rst; IMAck = s.imack; DMAck = s.dmack; MDDone = s.mddone;
            BrTaken = s.brtaken; Instr = s.instr;
            @(negedge clk);
            a_strb = {IMReq, IRWr, PCWr, RUWr, DMRd, DMWr, MDStart, Trap};
            a_dp   = {ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMCtrl, BrOp, RUDataWrSrc, MDOp};
            n_checks++;
            if (a_strb !== e.strb || (e.chk_st && (State !== e.st || TrapCause !== e.cause))) begin
                errors++;
                $display("FAIL cycle t=%0t: state=%0d strobes=%b cause=%b, required state=%0d strobes=%b cause=%b",
                         $time, State, a_strb, TrapCause, e.st, e.strb, e.cause);
            end
            if (e.chk_dp) begin
                n_checks++;
                if (a_dp !== e.dp) begin
                    errors++;
                    $display("FAIL ctrl t=%0t: got %h, required %h", $time, a_dp, e.dp);
                end
            end
            c_irwr += int'(IRWr); c_ruwr += int'(RUWr); c_pcwr += int'(PCWr);
            c_dmrd += int'(DMRd); c_mdst += int'(MDStart);
            c_fetch += int'(State == FETCH && !rst);
            if (State == EXECUTE) cap_dp = a_dp;
        end
    endtask

    initial begin
        rst = 1'b1; IMAck = 1'b0; DMAck = 1'b0; BrTaken = 1'b0; MDDone = 1'b0; Instr = NOP_INSTR;
        rst2 = 1'b1; ack2 = 1'b0; instr2 = NOP_INSTR; mcause = 2'b00;

        push_reset(FETCH, 1'b0, 2); play();
        chk("reset_state", int'(State), int'(FETCH));
        chk("reset_cause", int'(TrapCause), 0);

        push_instr(I_ADDI, 2, 0, 0, 1'b0, -1); play();
        chk("addi_irwr", c_irwr, 1); chk("addi_ruwr", c_ruwr, 1); chk("addi_pcwr", c_pcwr, 1);
        chk("addi_aluop", int'(cap_dp[21:18]), 0); chk("addi_bsrc", int'(cap_dp[13]), 1);

        push_instr(I_LW, 0, 3, 0, 1'b0, -1); play();
        chk("lw_dmrd", c_dmrd, 4); chk("lw_dmctrl", int'(cap_dp[12:10]), 2);
        chk("lw_rusrc", int'(cap_dp[4:3]), 1); chk("lw_ruwr", c_ruwr, 1);

        push_instr(I_BEQ, 1, 0, 0, 1'b1, -1); play();
        chk("beq_brop", int'(cap_dp[9:5]), 8); chk("beq_imm", int'(cap_dp[17:15]), 5);
        chk("beq_pcwr", c_pcwr, 1); chk("beq_ruwr", c_ruwr, 0);

        push_instr(I_SW, 0, 1, 0, 1'b0, -1);
        push_instr(I_SUB, 0, 0, 0, 1'b0, -1);
        push_instr(I_LUI, 1, 0, 0, 1'b0, -1);
        push_instr(I_JAL, 0, 0, 0, 1'b0, -1);
        push_instr(I_SRAI, 0, 0, 0, 1'b0, -1);
        push_instr(I_AUIPC, 0, 0, 0, 1'b0, -1);
        play();

        push_instr(I_SW, 0, 10, 0, 1'b0, 2);
        push_instr(I_ADDI, 0, 0, 0, 1'b0, -1); play();
        chk("sw_rst_pcwr", c_pcwr, 1);

`ifdef MULDIV_EN
        push_instr(I_MUL, 0, 0, 2, 1'b0, -1); play();
        chk("mul_mdstart", c_mdst, 1); chk("mul_rusrc", int'(cap_dp[4:3]), 3);
`else
        push_instr(I_MUL, 0, 0, 0, 1'b0, -1); play();
        chk("mul_cause", int'(TrapCause), 1); chk("mul_mdstart", c_mdst, 0);
        push_reset(TRAP, 1'b1, 2); play();
`endif

        push_instr(I_BADLD, 0, 0, 0, 1'b0, -1); play();
        chk("badld_cause", int'(TrapCause), 1);
        push_reset(TRAP, 1'b1, 2);
        push_instr(I_ONES, 0, 0, 0, 1'b0, -1); play();
        chk("ones_cause", int'(TrapCause), 1); chk("ones_trap", int'(Trap), 1);
        push_reset(TRAP, 1'b1, 2);
        push_instr(I_ADDI, 100, 0, 0, 1'b0, -1); play();
        chk("imto_fetch", c_fetch, 16); chk("imto_cause", int'(TrapCause), 2);
        push_reset(TRAP, 1'b1, 2);
        push_instr(I_SW, 0, 100, 0, 1'b0, -1); play();
        chk("dmto_cause", int'(TrapCause), 3);
        push_reset(TRAP, 1'b1, 2); play();

        @(posedge clk); #1; rst2 = 1'b0; ack2 = 1'b1; instr2 = I_ONES;
        @(negedge clk); chk("nh_irwr", int'(n_irwr), 1);
        @(posedge clk); #1; ack2 = 1'b0;
        @(negedge clk); chk("nh_decode", int'(n_state), int'(DECODE));
        @(posedge clk); #1;
        @(negedge clk);
        chk("nh_trap", int'(n_trap), 1); chk("nh_pcwr", int'(n_pcwr), 1); chk("nh_cause", int'(n_cause), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nh_fetch", int'(n_state), int'(FETCH)); chk("nh_trap_off", int'(n_trap), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, errors);
        $finish;
    end

endmodule
